// File: rtl/mult_div_seq.sv
// Iterative signed multiply/divide sequencer: radix-2 Booth multiply and
// restoring divide, one iteration per clock, HI/LO result pair with write strobe.
module mult_div_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic             hi_lo_write,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CNT_W   = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MULT = 3'd1,
        DIV  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } stateType;

    stateType         state;
    logic [CNT_W-1:0] iterCnt;
    // MULT: accA/accQ/qMinus1 form the Booth register, operandM the multiplicand.
    // DIV:  accA is the partial remainder, accQ shifts dividend out / quotient in,
    //       operandM is the divisor magnitude.
    logic [WIDTH-1:0] accA;
    logic [WIDTH-1:0] accQ;
    logic             qMinus1;
    logic [WIDTH-1:0] operandM;
    logic             negQuot;
    logic             negRem;

    logic [WIDTH:0]   boothSum;
    logic [WIDTH:0]   divShift;
    logic             divFits;
    logic [WIDTH-1:0] divRem;
    logic [WIDTH-1:0] absA;
    logic [WIDTH-1:0] absB;

    // Booth add/subtract is done one bit wider so the -2^(W-1) multiplicand cannot overflow before the shift.
    always_comb begin
        boothSum = {accA[WIDTH-1], accA};
        case ({accQ[0], qMinus1})
            2'b01:   boothSum = {accA[WIDTH-1], accA} + {operandM[WIDTH-1], operandM};
            2'b10:   boothSum = {accA[WIDTH-1], accA} - {operandM[WIDTH-1], operandM};
            default: boothSum = {accA[WIDTH-1], accA};
        endcase
    end

    // Restoring divide step: shift in next dividend bit, subtract divisor if it fits.
    always_comb begin
        divShift = {accA, accQ[WIDTH-1]};
        divFits  = (divShift >= {1'b0, operandM});
        divRem   = divShift[WIDTH-1:0];
        if (divFits) begin
            divRem = WIDTH'(divShift - {1'b0, operandM});
        end
    end

    // Operand magnitudes for the divider; |-2^(W-1)| is representable as unsigned.
    always_comb begin
        absA = src_a[WIDTH-1] ? (~src_a + WIDTH'(1)) : src_a;
        absB = src_b[WIDTH-1] ? (~src_b + WIDTH'(1)) : src_b;
    end

    // Sequencer state, datapath registers and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            iterCnt     <= '0;
            accA        <= '0;
            accQ        <= '0;
            qMinus1     <= 1'b0;
            operandM    <= '0;
            negQuot     <= 1'b0;
            negRem      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_zero    <= 1'b0;
            hi_lo_write <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            done        <= 1'b0;
            div_zero    <= 1'b0;
            hi_lo_write <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        iterCnt <= '0;
                        if (!op) begin
                            operandM <= src_a;
                            accA     <= '0;
                            accQ     <= src_b;
                            qMinus1  <= 1'b0;
                            busy     <= 1'b1;
                            state    <= MULT;
                        end else if (src_b == '0) begin
                            done     <= 1'b1;
                            div_zero <= 1'b1;
                            state    <= DONE;
                        end else begin
                            operandM <= absB;
                            accA     <= '0;
                            accQ     <= absA;
                            negQuot  <= src_a[WIDTH-1] ^ src_b[WIDTH-1];
                            negRem   <= src_a[WIDTH-1];
                            busy     <= 1'b1;
                            state    <= DIV;
                        end
                    end
                end
                MULT: begin
                    accA    <= boothSum[WIDTH:1];
                    accQ    <= {boothSum[0], accQ[WIDTH-1:1]};
                    qMinus1 <= accQ[0];
                    iterCnt <= iterCnt + CNT_W'(1);
                    if (iterCnt == LAST_ITER) begin
                        hi          <= boothSum[WIDTH:1];
                        lo          <= {boothSum[0], accQ[WIDTH-1:1]};
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        hi_lo_write <= 1'b1;
                        state       <= DONE;
                    end
                end
                DIV: begin
                    accA    <= divRem;
                    accQ    <= {accQ[WIDTH-2:0], divFits};
                    iterCnt <= iterCnt + CNT_W'(1);
                    if (iterCnt == LAST_ITER) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    // Quotient sign from operand signs, remainder sign from dividend.
                    lo          <= negQuot ? (~accQ + WIDTH'(1)) : accQ;
                    hi          <= negRem  ? (~accA + WIDTH'(1)) : accA;
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    hi_lo_write <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_seq.sv
// Directed-vector bench for mult_div_seq: latency, busy profile, results, aborts.
module tb_mult_div_seq;

    logic        clock;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic        hi_lo_write;
    logic [31:0] hi;
    logic [31:0] lo;

    int vecCount = 0;
    int missCount = 0;

    mult_div_seq #(.WIDTH(32)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .src_a       (src_a),
        .src_b       (src_b),
        .busy        (busy),
        .done        (done),
        .div_zero    (div_zero),
        .hi_lo_write (hi_lo_write),
        .hi          (hi),
        .lo          (lo)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Issue one operation and observe cycles 1.. after the capture edge (sampled on negedge).
    // injectCyc > 0 raises a second start with other operands in that cycle.
    task automatic runOp(input logic o, input logic [31:0] a, input logic [31:0] b,
                         input int injectCyc,
                         output int doneCyc, output int busyErrs, output int widthErr,
                         output logic [31:0] rh, output logic [31:0] rl,
                         output logic dz, output logic hw);
        doneCyc = -1; busyErrs = 0; widthErr = 0;
        rh = 32'h0; rl = 32'h0; dz = 1'b0; hw = 1'b0;
        @(negedge clock);
        op = o; src_a = a; src_b = b; start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0; src_a = $urandom; src_b = $urandom;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clock);
            if (k == injectCyc) begin
                start = 1'b1; op = ~o; src_a = 32'h5; src_b = 32'h9;
            end else if (k == injectCyc + 1) begin
                start = 1'b0;
            end
            if (doneCyc < 0) begin
                if (done === 1'b1) begin
                    doneCyc = k; rh = hi; rl = lo; dz = div_zero; hw = hi_lo_write;
                    if (busy !== 1'b0) busyErrs++;
                end else if (busy !== 1'b1) begin
                    busyErrs++;
                end
            end else begin
                if (done !== 1'b0 || div_zero !== 1'b0 || hi_lo_write !== 1'b0) widthErr = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; op = 1'b0; src_a = 32'h0; src_b = 32'h0;
        repeat (2) @(negedge clock);
        vecCount++; if (busy !== 1'b0) begin missCount++; $display("FAIL reset_busy got %b want 0", busy); end
        vecCount++; if (done !== 1'b0) begin missCount++; $display("FAIL reset_done got %b want 0", done); end
        vecCount++; if (div_zero !== 1'b0) begin missCount++; $display("FAIL reset_div_zero got %b want 0", div_zero); end
        vecCount++; if (hi_lo_write !== 1'b0) begin missCount++; $display("FAIL reset_hlw got %b want 0", hi_lo_write); end
        vecCount++; if (hi !== 32'h0 || lo !== 32'h0) begin missCount++; $display("FAIL reset_hilo got %h/%h want 0/0", hi, lo); end
        reset = 1'b1;
    endtask

    // Shared result checks for a normal (non div-by-zero) operation.
    task automatic test_arith(input string name, input logic o, input logic [31:0] a, input logic [31:0] b,
                              input int injectCyc, input int expCyc,
                              input logic [31:0] expHi, input logic [31:0] expLo);
        int dc, be, we;
        logic [31:0] rh, rl;
        logic dz, hw;
        runOp(o, a, b, injectCyc, dc, be, we, rh, rl, dz, hw);
        vecCount++; if (dc !== expCyc) begin missCount++; $display("FAIL %s latency got %0d want %0d", name, dc, expCyc); end
        vecCount++; if (rh !== expHi) begin missCount++; $display("FAIL %s hi got %h want %h", name, rh, expHi); end
        vecCount++; if (rl !== expLo) begin missCount++; $display("FAIL %s lo got %h want %h", name, rl, expLo); end
        vecCount++; if (hw !== 1'b1 || dz !== 1'b0) begin missCount++; $display("FAIL %s strobes got hlw=%b dz=%b want 1/0", name, hw, dz); end
        vecCount++; if (be !== 0) begin missCount++; $display("FAIL %s busy_profile got %0d bad cycles want 0", name, be); end
        vecCount++; if (we !== 0) begin missCount++; $display("FAIL %s pulse_width got %0d want 0", name, we); end
    endtask

    task automatic test_mult();
        test_arith("mult_7_m3",      1'b0, 32'h00000007, 32'hFFFFFFFD, 0, 33, 32'hFFFFFFFF, 32'hFFFFFFEB);
        test_arith("mult_min_min",   1'b0, 32'h80000000, 32'h80000000, 0, 33, 32'h40000000, 32'h00000000);
        test_arith("mult_m1_m1",     1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 33, 32'h00000000, 32'h00000001);
        test_arith("mult_big_x16",   1'b0, 32'h12345678, 32'h00000010, 0, 33, 32'h00000001, 32'h23456780);
    endtask

    task automatic test_div();
        test_arith("div_m7_2",       1'b1, 32'hFFFFFFF9, 32'h00000002, 0, 34, 32'hFFFFFFFF, 32'hFFFFFFFD);
        test_arith("div_7_m2",       1'b1, 32'h00000007, 32'hFFFFFFFE, 0, 34, 32'h00000001, 32'hFFFFFFFD);
        test_arith("div_100_7",      1'b1, 32'd100,      32'd7,        0, 34, 32'h00000002, 32'h0000000E);
        test_arith("div_min_m1",     1'b1, 32'h80000000, 32'hFFFFFFFF, 0, 34, 32'h00000000, 32'h80000000);
    endtask

    task automatic test_div_zero();
        int dc, be, we;
        logic [31:0] rh, rl;
        logic dz, hw;
        // 0x692 / 0x20 = 0x34 rem 0x12 leaves a known HI/LO pair.
        test_arith("div_preload", 1'b1, 32'h00000692, 32'h00000020, 0, 34, 32'h00000012, 32'h00000034);
        runOp(1'b1, 32'h5, 32'h0, 0, dc, be, we, rh, rl, dz, hw);
        vecCount++; if (dc !== 1) begin missCount++; $display("FAIL divz latency got %0d want 1", dc); end
        vecCount++; if (dz !== 1'b1) begin missCount++; $display("FAIL divz flag got %b want 1", dz); end
        vecCount++; if (hw !== 1'b0) begin missCount++; $display("FAIL divz hlw got %b want 0", hw); end
        vecCount++; if (hi !== 32'h12 || lo !== 32'h34) begin missCount++; $display("FAIL divz hold got %h/%h want 00000012/00000034", hi, lo); end
        vecCount++; if (be !== 0 || we !== 0) begin missCount++; $display("FAIL divz busy_width got %0d/%0d want 0/0", be, we); end
    endtask

    task automatic test_ignored_start();
        test_arith("mult_restart_ignored", 1'b0, 32'h00000007, 32'hFFFFFFFD, 5, 33, 32'hFFFFFFFF, 32'hFFFFFFEB);
    endtask

    task automatic test_reset_abort();
        int sawDone;
        @(negedge clock);
        op = 1'b1; src_a = 32'd100; src_b = 32'd7; start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (10) @(negedge clock);
        reset = 1'b0;
        #1;
        vecCount++; if (busy !== 1'b0 || done !== 1'b0 || div_zero !== 1'b0 || hi_lo_write !== 1'b0)
            begin missCount++; $display("FAIL abort_flags got b=%b d=%b z=%b w=%b want 0", busy, done, div_zero, hi_lo_write); end
        vecCount++; if (hi !== 32'h0 || lo !== 32'h0) begin missCount++; $display("FAIL abort_hilo got %h/%h want 0/0", hi, lo); end
        sawDone = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            if (done !== 1'b0 || busy !== 1'b0) sawDone++;
        end
        reset = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clock);
            if (done !== 1'b0) sawDone++;
        end
        vecCount++; if (sawDone !== 0) begin missCount++; $display("FAIL abort_no_done got %0d activity cycles want 0", sawDone); end
        test_arith("mult_after_abort", 1'b0, 32'd3, 32'd4, 0, 33, 32'h00000000, 32'h0000000C);
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_ignored_start();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
